bus_timer: RTL and testbench
============================

# bus_timer

Memory-mapped timer responder on the CPU's 16-bit data bus, decoded by the toplevel at 0xff20–0xff2f and read through the same registered-read mux as the UART and debug adapter. It answers CPU-initiated reads and writes with one-cycle read latency. It provides a prescaled 16-bit down-counter with one-shot/auto-reload modes, a sticky expiry flag with a level interrupt, and a 32-bit free-running cycle counter with an atomic high-half snapshot.

## Interface
- No parameters; register map and widths are fixed.
- clk  in  1  system clock (CPU bus clock)
- reset  in  1  synchronous, active-high; one clock, reset is synchronous and active-high
- ce  in  1  block select from toplevel address decode
- addr  in  16  byte address; only addr[3:1] (word offset) is used
- bwe  in  2  byte write enables, already gated by ce; bwe[1] writes din[15:8], bwe[0] writes din[7:0]
- din  in  16  write data from CPU
- dout  out  16  registered read data
- irq  out  1  level interrupt = flag & CTRL.irq_en

## Operation
- Registers, by word offset addr[3:1]:
  - 0 CTRL: bit0 enable, bit1 auto_reload, bit2 irq_en, bits15:8 presc. Bits 7:3 read 0.
  - 1 RELOAD: 16-bit.
  - 2 COUNT: reads the live count; a write loads it.
  - 3 STATUS: bit0 flag (write 1 clears, write 0 no effect), bit1 = CTRL.enable (read-only).
  - 4 TICKLO: live cycle counter [15:0].
  - 5 TICKHI: snapshot register.
  - Offsets 6–7 read 0; writes to them and to 4–5 are ignored.
- Byte writes:
  - Each bwe bit updates only its byte.
  - A CTRL write with bwe[1] also zeroes the prescaler.
- Prescaler: 8-bit pre.
  - tick = enable & (pre == presc).
  - On tick, pre←0; otherwise, if enabled, pre←pre+1.
  - While disabled, pre holds 0.
- On tick:
  - If COUNT≠0: COUNT←COUNT−1.
  - If COUNT==0: flag←1.
    - If auto_reload: COUNT←RELOAD.
    - Otherwise: COUNT stays 0 and enable←0 (one-shot stop).
- Expiry period: auto-reload period = (presc+1)·(RELOAD+1) clocks.
- Cycle counter: tick32 increments every clock, wraps 0xffffffff→0.
  - Read of TICKLO (ce & bwe==0 & offset 4) captures the cycle-N values.
  - The same cycle, TICKHI snapshot ← tick32[31:16] of that cycle, giving a coherent 32-bit pair.
- Read data: on every cycle with ce & bwe==0, dout ← selected register. Otherwise dout ← 0.
- Write precedence when events coincide:
  - COUNT bus write beats tick decrement/reload.
  - Flag set by expiry beats a same-cycle clear write.
  - CTRL bus write beats one-shot enable clear.
  - RELOAD written on an expiry cycle: the old RELOAD is loaded.

## Timing
- Reset values: CTRL, RELOAD, COUNT, flag, pre, tick32, TICKHI snapshot, dout and irq are all 0.
- Read latency is 1 cycle: address presented in cycle N, dout valid in N+1; the toplevel samples with its registered select.
- Writes take effect at the clock edge ending the bwe cycle. A read of the same register in the next cycle returns the new value.
- irq is registered-equivalent. It rises on the clock edge where flag sets (if irq_en) and falls on the edge where the clear write lands or irq_en is cleared.
- Enabling with presc=0: the first tick occurs the cycle after the enable write.
- Reset mid-count: all state returns to reset values on the next edge; no expiry is reported.
- No wait states; the block never stalls the CPU.

## Test plan
- Reset → read all 8 offsets: CTRL/RELOAD/COUNT/STATUS read 0; TICKLO reads a small nonzero live value; offsets 6–7 read 0; irq=0.
- RELOAD=3, COUNT=3, CTRL=0x0007 (presc 0, auto, irq) → flag/irq rise every 4 clocks. After STATUS write 0x0001, irq drops and reasserts 4 clocks after the previous expiry.
- presc=0x04, COUNT=2, one-shot, enable → flag at clock 15 after enable. STATUS reads 0x0001 (bit1 cleared), COUNT holds 0.
- Byte write bwe=2'b10 to CTRL with din=0xff55 → presc=0xff, low control bits unchanged, pre zeroed.
- Preload tick32 to 0x0000fffe via reset timing, read TICKLO then TICKHI across the 16-bit carry → the pair is consistent (0xffff/0x0000 or 0x0000/0x0001), never mixed.
- COUNT write on the same cycle as a tick, and a STATUS clear on the same cycle as expiry → written COUNT value wins; flag remains set.

Source files
------------

// File: rtl/bus_timer.sv
// bus_timer: bus-mapped prescaled down-counter with expiry flag/irq and a 32-bit
// cycle counter whose high half is snapshotted when the low half is read.
module bus_timer (
  input  logic        clk,
  input  logic        reset,
  input  logic        ce,
  input  logic [15:0] addr,
  input  logic [1:0]  bwe,
  input  logic [15:0] din,
  output logic [15:0] dout,
  output logic        irq
);
  logic        en_q, en_d, auto_q, auto_d, ien_q, ien_d, flag_q, flag_d;
  logic [7:0]  presc_q, presc_d, pre_q, pre_d;
  logic [15:0] reload_q, reload_d, count_q, count_d, hi_q, hi_d, dout_q, dout_d;
  logic [31:0] tick32_q, tick32_d;
  logic [2:0]  off;
  logic [1:0]  we;
  logic        rd, tick, expire, ctrl_lo_w, ctrl_hi_w;
  logic [15:0] rmap [8];
  logic        unused;
  assign unused    = ^{addr[15:4], addr[0]};
  assign off       = addr[3:1];
  assign we        = ce ? bwe : 2'b00;
  assign rd        = ce & (bwe == 2'b00);
  assign ctrl_lo_w = (off == 3'd0) & we[0];
  assign ctrl_hi_w = (off == 3'd0) & we[1];
  assign tick      = en_q & (pre_q == presc_q);
  assign expire    = tick & (count_q == 16'd0);
  assign rmap[0]   = {presc_q, 5'd0, ien_q, auto_q, en_q};
  assign rmap[1]   = reload_q;
  assign rmap[2]   = count_q;
  assign rmap[3]   = {14'd0, en_q, flag_q};
  assign rmap[4]   = tick32_q[15:0];
  assign rmap[5]   = hi_q;
  assign rmap[6]   = 16'd0;
  assign rmap[7]   = 16'd0;
  // Bus writes take priority over the counter's own updates; expiry beats a flag clear.
  always_comb begin
    en_d     = ctrl_lo_w ? din[0] : (expire & ~auto_q) ? 1'b0 : en_q;
    auto_d   = ctrl_lo_w ? din[1] : auto_q;
    ien_d    = ctrl_lo_w ? din[2] : ien_q;
    presc_d  = ctrl_hi_w ? din[15:8] : presc_q;
    pre_d    = (ctrl_hi_w | tick | ~en_q) ? 8'd0 : pre_q + 8'd1;
    reload_d = (off == 3'd1) ? {we[1] ? din[15:8] : reload_q[15:8], we[0] ? din[7:0] : reload_q[7:0]} : reload_q;
    count_d  = (off == 3'd2 && we != 2'b00) ? {we[1] ? din[15:8] : count_q[15:8], we[0] ? din[7:0] : count_q[7:0]}
             : expire ? (auto_q ? reload_q : count_q)
             : tick ? count_q - 16'd1 : count_q;
    flag_d   = expire | (flag_q & ~((off == 3'd3) & we[0] & din[0]));
    tick32_d = tick32_q + 32'd1;
    hi_d     = (rd && off == 3'd4) ? tick32_q[31:16] : hi_q;
    dout_d   = rd ? rmap[off] : 16'd0;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      en_q     <= 1'b0;
      auto_q   <= 1'b0;
      ien_q    <= 1'b0;
      flag_q   <= 1'b0;
      presc_q  <= 8'd0;
      pre_q    <= 8'd0;
      reload_q <= 16'd0;
      count_q  <= 16'd0;
      hi_q     <= 16'd0;
      dout_q   <= 16'd0;
      tick32_q <= 32'd0;
    end else begin
      en_q     <= en_d;
      auto_q   <= auto_d;
      ien_q    <= ien_d;
      flag_q   <= flag_d;
      presc_q  <= presc_d;
      pre_q    <= pre_d;
      reload_q <= reload_d;
      count_q  <= count_d;
      hi_q     <= hi_d;
      dout_q   <= dout_d;
      tick32_q <= tick32_d;
    end
  end
  assign dout = dout_q;
  assign irq  = flag_q & ien_q;
endmodule

// File: tb/tb_bus_timer.sv
// tb_bus_timer: directed bench for bus_timer; expected read data queued at issue, checked on return.
module tb_bus_timer;
  logic        clk = 1'b0, reset = 1'b1, ce = 1'b0;
  logic [15:0] addr = 16'd0, din = 16'd0, dout;
  logic [1:0]  bwe = 2'b00;
  logic        irq;
  logic [31:0] t32;
  int          total = 0, bad = 0;
  typedef struct {logic [15:0] v; string tag;} exp_t;
  exp_t sb[$];
  bus_timer dut (.clk(clk), .reset(reset), .ce(ce), .addr(addr), .bwe(bwe), .din(din), .dout(dout), .irq(irq));
  always #5 clk = ~clk;
  always @(posedge clk) t32 <= reset ? 32'd0 : t32 + 32'd1;
  task automatic cyc;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input logic [15:0] obs, input logic [15:0] exp, input string tag);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic wr(input int off, input logic [15:0] d, input logic [1:0] be);
    ce = 1'b1; addr = 16'hff20 + 16'(off * 2); bwe = be; din = d;
    cyc();
    ce = 1'b0; bwe = 2'b00; din = 16'd0;
  endtask
  task automatic rd(input int off, input logic [15:0] e, input string tag);
    exp_t x;
    ce = 1'b1; addr = 16'hff20 + 16'(off * 2); bwe = 2'b00;
    sb.push_back('{v: e, tag: tag});
    cyc();
    ce = 1'b0;
    x = sb.pop_front();
    chk(dout, x.v, x.tag);
  endtask
  initial begin
    repeat (3) cyc();
    reset = 1'b0;
    chk(dout, 16'd0, "rst_dout");
    chk({15'd0, irq}, 16'd0, "rst_irq");
    rd(0, 16'd0, "rst_ctrl");
    rd(1, 16'd0, "rst_reload");
    rd(2, 16'd0, "rst_count");
    rd(3, 16'd0, "rst_status");
    rd(4, t32[15:0], "rst_ticklo");
    rd(5, 16'd0, "rst_tickhi");
    rd(6, 16'd0, "rst_off6");
    rd(7, 16'd0, "rst_off7");
    // auto-reload, presc 0: expiry every 4 clocks
    wr(1, 16'd3, 2'b11);
    wr(2, 16'd3, 2'b11);
    wr(0, 16'h0007, 2'b11);
    repeat (3) cyc();
    chk({15'd0, irq}, 16'd0, "ar_before");
    cyc();
    chk({15'd0, irq}, 16'd1, "ar_first");
    rd(2, 16'd3, "ar_reloaded");
    wr(3, 16'h0001, 2'b01);
    chk({15'd0, irq}, 16'd0, "ar_cleared");
    cyc();
    chk({15'd0, irq}, 16'd0, "ar_still_low");
    cyc();
    chk({15'd0, irq}, 16'd1, "ar_again");
    repeat (3) cyc();
    wr(3, 16'h0001, 2'b01);
    chk({15'd0, irq}, 16'd1, "clr_vs_expiry");
    rd(3, 16'h0003, "st_flag_en");
    wr(2, 16'h0100, 2'b11);
    rd(2, 16'h0100, "cnt_write_wins");
    wr(0, 16'h0000, 2'b11);
    chk({15'd0, irq}, 16'd0, "ien_off");
    wr(3, 16'h0001, 2'b01);
    rd(3, 16'h0000, "st_idle");
    // one-shot, presc 4, COUNT 2: flag 15 clocks after enable
    wr(0, 16'h0400, 2'b11);
    wr(2, 16'd2, 2'b11);
    wr(0, 16'h0401, 2'b01);
    repeat (14) cyc();
    rd(3, 16'h0002, "os_running");
    rd(3, 16'h0001, "os_expired");
    rd(2, 16'h0000, "os_count0");
    rd(0, 16'h0400, "os_ctrl");
    chk({15'd0, irq}, 16'd0, "os_irq_masked");
    // high-byte CTRL write sets presc and zeroes the prescaler
    wr(3, 16'h0001, 2'b01);
    wr(2, 16'd5, 2'b11);
    wr(0, 16'h0303, 2'b11);
    repeat (2) cyc();
    wr(0, 16'hff55, 2'b10);
    rd(0, 16'hff03, "bw_ctrl");
    repeat (254) cyc();
    rd(2, 16'd5, "bw_pre_hold");
    rd(2, 16'd4, "bw_pre_tick");
    wr(6, 16'hffff, 2'b11);
    rd(6, 16'd0, "off6_ignored");
    wr(1, 16'h1234, 2'b11);
    wr(1, 16'hab56, 2'b01);
    rd(1, 16'h1256, "reload_lo_byte");
    cyc();
    chk(dout, 16'd0, "idle_dout");
    // reset while counting
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    chk({15'd0, irq}, 16'd0, "mr_irq");
    rd(0, 16'd0, "mr_ctrl");
    rd(2, 16'd0, "mr_count");
    rd(3, 16'd0, "mr_status");
    // coherent TICKLO/TICKHI pairs across the 16-bit carry
    repeat (32'h0000fffe - t32) cyc();
    rd(4, 16'hfffe, "tl_pre_carry");
    rd(5, 16'h0000, "th_pre_carry");
    rd(4, 16'h0000, "tl_post_carry");
    rd(5, 16'h0001, "th_post_carry");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
